noc_output_alloc: RTL and testbench
===================================

Name: noc_output_alloc

Overview:
- Per-output-port allocator for the NoC router.
- Shares one output link between N_IN input ports (local plus four directions) using wormhole switching and round-robin fairness between packets.
- Holds the downstream credit count, so a flit is granted only when the next router has buffer space.
- Sits between the input-buffer request logic and the crossbar select for one output port.

Parameters:
N_IN, 5, number of requesting input ports
CREDITS, 4, downstream buffer depth in flits; reset value of the credit counter
OW, $clog2(N_IN), owner and pointer width (derived)
CW, $clog2(CREDITS+1), credit counter width (derived)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
req  input  N_IN  req[i]=1: input i has a flit ready for this output
head  input  N_IN  head[i]=1: the flit at input i is a head flit
tail  input  N_IN  tail[i]=1: the flit at input i is a tail flit; head&tail means a single-flit packet
credit_in  input  1  one-cycle pulse: downstream has freed one buffer slot
grant  output  N_IN  one-hot or zero; flit from input i crosses the link this cycle; combinational from registered state and current inputs
send  output  1  OR of grant; drives downstream valid
locked  output  1  registered; 1 while a multi-flit packet owns the port
owner  output  OW  registered; index of the locking input, valid when locked=1
credit_cnt  output  CW  registered credit count
cr_err  output  1  sticky; set on credit overflow, cleared only by reset

Behaviour:
- Reset (asynchronous, while reset=1): state=IDLE, ptr=0, owner=0, locked=0, credit_cnt=CREDITS, cr_err=0, grant=0, send=0.
- Grant is produced in the same cycle as the request (zero latency). State updates on the next rising edge.
- State IDLE:
  - Eligible inputs: i with req[i]&head[i].
  - A grant is allowed only if credit_cnt>0, using the registered count.
  - Winner: first eligible index scanning ptr, ptr+1, ..., N_IN-1, 0, ..., ptr-1.
  - grant[winner]=1.
  - Non-head requests in IDLE are ignored and never granted.
  - If tail[winner]=1 (single-flit packet): stay in IDLE, ptr <= (winner+1) mod N_IN.
  - Else: go to LOCKED, owner <= winner, locked <= 1. ptr is unchanged.
- State LOCKED:
  - grant[owner] = req[owner] & (credit_cnt>0). All other inputs get grant=0, even with head=1.
  - head is ignored for the owner.
  - If granted with tail[owner]=1: go to IDLE, locked <= 0, ptr <= (owner+1) mod N_IN.
  - If req[owner]=0 (bubble): stay LOCKED, no grant.
- Credits:
  - credit_cnt_next = credit_cnt - send + credit_in.
  - send and credit_in in the same cycle: count unchanged.
  - credit_cnt=0 and credit_in=1 in the same cycle: no send this cycle; count becomes 1 next cycle.
  - Overflow (credit_in=1, send=0, credit_cnt=CREDITS): count holds at CREDITS and cr_err <= 1.
  - Underflow is impossible by construction; the bench asserts it never occurs.
- Pointer wrap: (N_IN-1)+1 wraps to 0.
- Invariants (bench assertions):
  - grant has at most one bit set.
  - send=1 implies credit_cnt>0.
  - locked=1 implies no grant to any input other than owner.
- Reset during LOCKED mid-packet: everything returns to reset values; the partial packet is abandoned, with no grant in the reset cycles.
- First cycle after reset release: arbitration is normal with ptr=0.

Test Plan:
- Reset, then req=5'b00100, head=tail=5'b00100 -> grant=5'b00100 same cycle; ptr=3; locked stays 0; credit_cnt 4->3.
- All five inputs request single-flit packets every cycle, credit_in=1 every cycle -> grants rotate 0,1,2,3,4,0; credit_cnt stays 4.
- Input 1 sends a 3-flit packet (head, body, tail) while input 3 holds a head request -> grant=00010 for 3 cycles with locked=1 and owner=1; input 3 is granted in cycle 4.
- No credit_in, input 0 streams 6 single-flit packets -> 4 grants, then send=0 with credit_cnt=0; one credit_in pulse -> exactly one more grant, issued the cycle after the pulse.
- credit_in pulsed at credit_cnt=4 with no send -> credit_cnt stays 4 and cr_err=1, sticky until reset.
- Assert reset mid-packet with input 2 locked -> grant=0 and locked=0 immediately; after release, credit_cnt=4, ptr=0, and an input-2 body flit with head=0 is not granted.

Source files
------------

// File: rtl/noc_output_alloc_if.sv
// Handshake bundle between the input-buffer request logic and one output-port
// allocator: per-input requests and flit markers in, grant/credit status out.
interface noc_output_alloc_if #(
    parameter int N_IN    = 5,
    parameter int CREDITS = 4,
    localparam int OW     = $clog2(N_IN),
    localparam int CW     = $clog2(CREDITS + 1)
);
    logic [N_IN-1:0] req;
    logic [N_IN-1:0] head;
    logic [N_IN-1:0] tail;
    logic            credit_in;
    logic [N_IN-1:0] grant;
    logic            send;
    logic            locked;
    logic [OW-1:0]   owner;
    logic [CW-1:0]   credit_cnt;
    logic            cr_err;

    // Request side: drives flit requests and returning credits.
    modport master (
        output req, head, tail, credit_in,
        input  grant, send, locked, owner, credit_cnt, cr_err
    );

    // Allocator side.
    modport slave (
        input  req, head, tail, credit_in,
        output grant, send, locked, owner, credit_cnt, cr_err
    );
endinterface

// File: rtl/noc_output_alloc.sv
// Output-port allocator: wormhole switching with round-robin fairness between
// packets and credit-based flow control toward the downstream router.
module noc_output_alloc #(
    parameter int N_IN    = 5,
    parameter int CREDITS = 4,
    localparam int OW     = $clog2(N_IN),
    localparam int CW     = $clog2(CREDITS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    noc_output_alloc_if.slave bus
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state_reg, state_next;
    logic [OW-1:0]   ptr_reg, ptr_next;
    logic [OW-1:0]   owner_reg, owner_next;
    logic [CW-1:0]   credit_reg, credit_next;
    logic            cr_err_reg, cr_err_next;

    logic [N_IN-1:0] eligible;
    logic [OW-1:0]   winner;
    logic            found;
    logic            credit_ok;
    logic [N_IN-1:0] grant;
    logic            send;

    // Round-robin advance past the given input, wrapping the last index to 0.
    function automatic logic [OW-1:0] wrap_inc(input logic [OW-1:0] v);
        return (v == OW'(N_IN - 1)) ? '0 : v + OW'(1);
    endfunction

    assign credit_ok = (credit_reg != '0);

    // Only head flits may open a new packet on an idle port.
    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_elig
            assign eligible[gi] = bus.req[gi] & bus.head[gi];
        end
    endgenerate

    // Round-robin search: first eligible input starting at ptr and wrapping.
    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < N_IN; k++) begin
            idx = int'(ptr_reg) + k;
            if (idx >= N_IN) idx = idx - N_IN;
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = OW'(idx);
            end
        end
    end

    // Output decode: zero-latency grant, suppressed while reset is asserted.
    always_comb begin
        grant = '0;
        if (!reset) begin
            case (state_reg)
                IDLE:    if (found && credit_ok) grant[winner] = 1'b1;
                LOCKED:  grant[owner_reg] = bus.req[owner_reg] & credit_ok;
                default: grant = '0;
            endcase
        end
    end

    assign send = |grant;

    // Next-state: packet lock/unlock, pointer advance and credit accounting.
    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        owner_next  = owner_reg;
        credit_next = credit_reg;
        cr_err_next = cr_err_reg;

        case (state_reg)
            IDLE: begin
                if (send) begin
                    if (bus.tail[winner]) begin
                        ptr_next = wrap_inc(winner);
                    end else begin
                        state_next = LOCKED;
                        owner_next = winner;
                    end
                end
            end
            LOCKED: begin
                if (send && bus.tail[owner_reg]) begin
                    state_next = IDLE;
                    ptr_next   = wrap_inc(owner_reg);
                end
            end
            default: state_next = IDLE;
        endcase

        // A returning credit with the counter already full is a protocol error;
        // the count saturates rather than wrapping.
        case ({send, bus.credit_in})
            2'b10: credit_next = credit_reg - CW'(1);
            2'b01: begin
                if (credit_reg == CW'(CREDITS)) cr_err_next = 1'b1;
                else                            credit_next = credit_reg + CW'(1);
            end
            default: credit_next = credit_reg;
        endcase
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            ptr_reg    <= '0;
            owner_reg  <= '0;
            credit_reg <= CW'(CREDITS);
            cr_err_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            owner_reg  <= owner_next;
            credit_reg <= credit_next;
            cr_err_reg <= cr_err_next;
        end
    end

    assign bus.grant      = grant;
    assign bus.send       = send;
    assign bus.locked     = (state_reg == LOCKED);
    assign bus.owner      = owner_reg;
    assign bus.credit_cnt = credit_reg;
    assign bus.cr_err     = cr_err_reg;
endmodule

// File: tb/tb_noc_output_alloc.sv
// Directed bench for noc_output_alloc: arbitration order, wormhole locking,
// credit flow control, overflow flag and asynchronous reset mid-packet.
module tb_noc_output_alloc;
    localparam int N_IN    = 5;
    localparam int CREDITS = 4;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    noc_output_alloc_if #(.N_IN(N_IN), .CREDITS(CREDITS)) bif ();

    noc_output_alloc #(.N_IN(N_IN), .CREDITS(CREDITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts, and reports any mismatch.
    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [N_IN-1:0] r, input logic [N_IN-1:0] h,
                          input logic [N_IN-1:0] t, input logic c);
        bif.req       = r;
        bif.head      = h;
        bif.tail      = t;
        bif.credit_in = c;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_in('0, '0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Structural invariants, sampled mid-cycle when inputs are stable.
    always @(negedge clk) begin
        logic [N_IN-1:0] others;
        others = bif.grant & ~(N_IN'(1) << bif.owner);
        if (!reset) begin
            check("inv_onehot", 32'($onehot0(bif.grant)), 1);
            check("inv_send_credit", 32'(bif.send && (bif.credit_cnt == 0)), 0);
            check("inv_lock_excl", 32'(bif.locked && (others != '0)), 0);
            check("inv_no_underflow", 32'(bif.credit_cnt <= 3'(CREDITS)), 1);
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        set_in(5'b11111, 5'b11111, 5'b11111, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        // Reset state, with requests present
        check("rst_grant", bif.grant, 0);
        check("rst_send", bif.send, 0);
        check("rst_locked", bif.locked, 0);
        check("rst_owner", bif.owner, 0);
        check("rst_credit", bif.credit_cnt, 4);
        check("rst_err", bif.cr_err, 0);
        reset = 1'b0;

        // Single-flit packet from input 2, then ptr=3 picks input 3
        set_in(5'b00100, 5'b00100, 5'b00100, 1'b0);
        #1;
        check("t1_grant", bif.grant, 5'b00100);
        check("t1_send", bif.send, 1);
        cyc();
        check("t1_locked", bif.locked, 0);
        check("t1_credit", bif.credit_cnt, 3);
        set_in(5'b11111, 5'b11111, 5'b11111, 1'b0);
        #1;
        check("t1_ptr3_grant", bif.grant, 5'b01000);
        cyc();
        check("t1_credit2", bif.credit_cnt, 2);

        // Full load with credits returning every cycle: strict rotation
        do_reset();
        for (int c = 0; c < 6; c++) begin
            set_in(5'b11111, 5'b11111, 5'b11111, 1'b1);
            #1;
            check($sformatf("t2_grant%0d", c), bif.grant, 32'(1) << (c % 5));
            cyc();
            check($sformatf("t2_credit%0d", c), bif.credit_cnt, 4);
        end

        // 3-flit packet from input 1 with a bubble, input 3 waiting with a head
        do_reset();
        set_in(5'b01010, 5'b01010, 5'b01000, 1'b0);
        #1;
        check("t3_head_grant", bif.grant, 5'b00010);
        cyc();
        check("t3_locked_a", bif.locked, 1);
        check("t3_owner_a", bif.owner, 1);
        check("t3_credit_a", bif.credit_cnt, 3);
        set_in(5'b01010, 5'b01000, 5'b01000, 1'b0);
        #1;
        check("t3_body_grant", bif.grant, 5'b00010);
        cyc();
        check("t3_locked_b", bif.locked, 1);
        set_in(5'b01000, 5'b01000, 5'b01000, 1'b0);
        #1;
        check("t3_bubble_grant", bif.grant, 0);
        cyc();
        check("t3_locked_c", bif.locked, 1);
        check("t3_credit_c", bif.credit_cnt, 2);
        set_in(5'b01010, 5'b01000, 5'b01010, 1'b0);
        #1;
        check("t3_tail_grant", bif.grant, 5'b00010);
        cyc();
        check("t3_unlocked", bif.locked, 0);
        check("t3_credit_d", bif.credit_cnt, 1);
        set_in(5'b01000, 5'b01000, 5'b01000, 1'b0);
        #1;
        check("t3_in3_grant", bif.grant, 5'b01000);
        cyc();
        check("t3_credit_e", bif.credit_cnt, 0);

        // Credit exhaustion and single credit return
        do_reset();
        for (int c = 0; c < 6; c++) begin
            set_in(5'b00001, 5'b00001, 5'b00001, 1'b0);
            #1;
            check($sformatf("t4_grant%0d", c), bif.grant, (c < 4) ? 1 : 0);
            cyc();
        end
        check("t4_credit_zero", bif.credit_cnt, 0);
        set_in(5'b00001, 5'b00001, 5'b00001, 1'b1);
        #1;
        check("t4_pulse_grant", bif.grant, 0);
        cyc();
        check("t4_credit_one", bif.credit_cnt, 1);
        set_in(5'b00001, 5'b00001, 5'b00001, 1'b0);
        #1;
        check("t4_after_grant", bif.grant, 1);
        cyc();
        check("t4_credit_zero2", bif.credit_cnt, 0);
        #1;
        check("t4_no_grant", bif.grant, 0);

        // Overflow: credit returned while full
        do_reset();
        set_in('0, '0, '0, 1'b1);
        cyc();
        check("t5_credit_hold", bif.credit_cnt, 4);
        check("t5_err_set", bif.cr_err, 1);
        set_in('0, '0, '0, 1'b0);
        repeat (3) cyc();
        check("t5_err_sticky", bif.cr_err, 1);
        do_reset();
        check("t5_err_clear", bif.cr_err, 0);

        // Asynchronous reset while input 2 owns the port
        set_in(5'b00100, 5'b00100, 5'b00000, 1'b0);
        #1;
        check("t6_head_grant", bif.grant, 5'b00100);
        cyc();
        check("t6_locked", bif.locked, 1);
        check("t6_owner", bif.owner, 2);
        set_in(5'b00100, 5'b00000, 5'b00000, 1'b0);
        #1;
        check("t6_body_grant", bif.grant, 5'b00100);
        reset = 1'b1;
        #1;
        check("t6_rst_grant", bif.grant, 0);
        check("t6_rst_locked", bif.locked, 0);
        check("t6_rst_credit", bif.credit_cnt, 4);
        cyc();
        reset = 1'b0;
        #1;
        check("t6_body_ignored", bif.grant, 0);
        check("t6_credit_after", bif.credit_cnt, 4);
        cyc();
        check("t6_still_idle", bif.locked, 0);
        set_in(5'b11111, 5'b11111, 5'b11111, 1'b0);
        #1;
        check("t6_ptr0_grant", bif.grant, 5'b00001);
        cyc();

        set_in('0, '0, '0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
